// File: rtl/camera_scroll_ctrl.sv
// camera_scroll_ctrl: follows the player's world height one level at a time.
// A level crossing seen on an accepted frame tick starts a frame-stepped
// scroll; camera_y*LEVEL_HEIGHT + camera_offset rises or falls monotonically
// until the scroll settles, then level_changed pulses for one cycle.
module camera_scroll_ctrl #(
   parameter int PHY_WIDTH    = 16,
   parameter int CAMERA_WIDTH = 6,
   parameter int LEVEL_HEIGHT = 480,
   parameter int SCROLL_STEP  = 32,
   parameter int MAX_LEVEL    = 63
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    frame_tick,
   input  logic                    freeze,
   input  logic [PHY_WIDTH-1:0]    player_y,
   output logic [CAMERA_WIDTH-1:0] camera_y,
   output logic [PHY_WIDTH-1:0]    camera_offset,
   output logic                    scrolling,
   output logic                    level_changed
);

   localparam logic [PHY_WIDTH:0]      LH_W      = (PHY_WIDTH+1)'(LEVEL_HEIGHT);
   localparam logic [PHY_WIDTH:0]      SS_W      = (PHY_WIDTH+1)'(SCROLL_STEP);
   localparam logic [PHY_WIDTH-1:0]    LH_P      = PHY_WIDTH'(LEVEL_HEIGHT);
   localparam logic [PHY_WIDTH-1:0]    SS_P      = PHY_WIDTH'(SCROLL_STEP);
   localparam logic [CAMERA_WIDTH-1:0] MAX_C     = CAMERA_WIDTH'(MAX_LEVEL);
   localparam logic [CAMERA_WIDTH-1:0] ONE_C     = CAMERA_WIDTH'(1);
   localparam bit                      UP_INSTANT = (SCROLL_STEP >= LEVEL_HEIGHT);
   localparam int                      DOWN_START_I =
      (SCROLL_STEP >= LEVEL_HEIGHT) ? 0 : (LEVEL_HEIGHT - SCROLL_STEP);
   localparam logic [PHY_WIDTH-1:0]    DOWN_START = PHY_WIDTH'(DOWN_START_I);

   typedef enum logic [1:0] {
      SETTLED     = 2'd0,
      SCROLL_UP   = 2'd1,
      SCROLL_DOWN = 2'd2
   } state_t;

   state_t               state;
   logic [PHY_WIDTH-1:0] level_base;

   logic                 tick;
   logic [PHY_WIDTH:0]   player_ext;
   logic [PHY_WIDTH:0]   base_ext;
   logic [PHY_WIDTH:0]   top_ext;
   logic [PHY_WIDTH:0]   up_sum;
   logic                 go_up;
   logic                 go_down;
   logic                 up_done;
   logic                 down_done;

   // Level-crossing and scroll-completion decisions, one bit wider than the world
   always_comb begin
      tick       = frame_tick && !freeze;
      player_ext = {1'b0, player_y};
      base_ext   = {1'b0, level_base};
      top_ext    = base_ext + LH_W;
      up_sum     = {1'b0, camera_offset} + SS_W;
      go_up      = (player_ext >= top_ext) && (camera_y < MAX_C);
      go_down    = (player_ext < base_ext) && (camera_y != '0);
      up_done    = (up_sum >= LH_W);
      down_done  = (camera_offset <= SS_P);
   end

   // Scroll FSM with registered outputs; only accepted ticks advance it
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= SETTLED;
         level_base    <= '0;
         camera_y      <= '0;
         camera_offset <= '0;
         scrolling     <= 1'b0;
         level_changed <= 1'b0;
      end else begin
         level_changed <= 1'b0;
         if (tick) begin
            case (state)
               SETTLED: begin
                  if (go_up) begin
                     if (UP_INSTANT) begin
                        camera_y      <= camera_y + ONE_C;
                        level_base    <= level_base + LH_P;
                        camera_offset <= '0;
                        level_changed <= 1'b1;
                     end else begin
                        state         <= SCROLL_UP;
                        scrolling     <= 1'b1;
                        camera_offset <= SS_P;
                     end
                  end else if (go_down) begin
                     // The level index drops at the start of a down-scroll so
                     // the offset can count down from just under a full level.
                     camera_y   <= camera_y - ONE_C;
                     level_base <= level_base - LH_P;
                     if (DOWN_START == '0) begin
                        camera_offset <= '0;
                        level_changed <= 1'b1;
                     end else begin
                        state         <= SCROLL_DOWN;
                        scrolling     <= 1'b1;
                        camera_offset <= DOWN_START;
                     end
                  end
               end
               SCROLL_UP: begin
                  if (up_done) begin
                     state         <= SETTLED;
                     scrolling     <= 1'b0;
                     camera_y      <= camera_y + ONE_C;
                     level_base    <= level_base + LH_P;
                     camera_offset <= '0;
                     level_changed <= 1'b1;
                  end else begin
                     camera_offset <= camera_offset + SS_P;
                  end
               end
               SCROLL_DOWN: begin
                  if (down_done) begin
                     state         <= SETTLED;
                     scrolling     <= 1'b0;
                     camera_offset <= '0;
                     level_changed <= 1'b1;
                  end else begin
                     camera_offset <= camera_offset - SS_P;
                  end
               end
               default: begin
                  state     <= SETTLED;
                  scrolling <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
